// File: rtl/compare_pkg.sv
// compare_pkg: shared definitions for the sequential magnitude comparator.
//   - CMP_GT/CMP_EQ/CMP_LT : bit positions inside a {gt,eq,lt} result vector
//   - Y_GT/Y_EQ/Y_LT/Y_NONE: one-hot result constants (Y_NONE = no result)
//   - state_t              : controller states IDLE / BUSY / DONE
package compare_pkg;

    localparam int CMP_GT = 2;
    localparam int CMP_EQ = 1;
    localparam int CMP_LT = 0;

    localparam logic [2:0] Y_GT   = 3'b100;
    localparam logic [2:0] Y_EQ   = 3'b010;
    localparam logic [2:0] Y_LT   = 3'b001;
    localparam logic [2:0] Y_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/compare_chunk.sv
// compare_chunk: purely combinational CHUNK-bit unsigned magnitude compare.
//   a, b : CHUNK-bit unsigned operands
//   y    : one-hot {gt,eq,lt}
module compare_chunk
    import compare_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [2:0]       y
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch; a path that leaves it unassigned infers a latch.
        y = Y_NONE;
        if (a > b) begin
            y = Y_GT;
        end else if (a < b) begin
            y = Y_LT;
        end else begin
            y = Y_EQ;
        end
    end

endmodule

// File: rtl/compare_seq.sv
// compare_seq: multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per
// cycle, MSB chunk first, stopping at the first differing chunk.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, signed_mode sampled on it)
//   a, b                : WIDTH-bit operands
//   signed_mode         : 1 = two's-complement compare (only if SIGNED_EN)
//   out_valid/out_ready : result handshake
//   y                   : result {gt,eq,lt}, one-hot while out_valid
//   busy                : high while a transaction is in flight or waiting
module compare_seq
    import compare_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       y,
    output logic             busy
);

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("compare_seq: CHUNK must be >= 1");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("compare_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDX_W-1:0] idx;
    logic [2:0]       y_q;
    logic [2:0]       chunk_y;
    logic             accept;
    logic             decided;
    logic [WIDTH-1:0] flip;

    assign accept = in_valid && (state == IDLE);

    // Flipping the sign bit of both operands maps two's complement onto
    // offset binary, so every later compare can stay unsigned.
    assign flip = (SIGNED_EN && signed_mode) ? MSB_MASK : '0;

    // The operand registers shift left by CHUNK after each equal chunk, so
    // their top CHUNK bits always hold chunk idx of the captured operands.
    compare_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a (a_q[WIDTH-1 -: CHUNK]),
        .b (b_q[WIDTH-1 -: CHUNK]),
        .y (chunk_y)
    );

    // A differing chunk settles the result; so does the last chunk.
    assign decided = !chunk_y[CMP_EQ] || (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = BUSY;
            BUSY:    if (decided)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            idx <= '0;
            y_q <= Y_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= a ^ flip;
                        b_q <= b ^ flip;
                        idx <= '0;
                    end
                end
                BUSY: begin
                    if (decided) begin
                        // chunk_y is already Y_EQ when the last chunk matches.
                        y_q <= chunk_y;
                    end else begin
                        a_q <= a_q << CHUNK;
                        b_q <= b_q << CHUNK;
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign y         = y_q;

endmodule
